// File: rtl/pxs_score_keeper_pkg.sv
// Shared definitions for the score keeper: pixel-stream field layout, game states, winner codes.
package pxs_score_keeper_pkg;

    // 26-bit pixel stream layout: {rgb[5:0], xc[9:0], yc[9:0]}.
    localparam int unsigned StreamWidth = 26;
    localparam int unsigned CoordWidth  = 10;
    localparam int unsigned YcLsb       = 0;
    localparam int unsigned XcLsb       = 10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StOver = 2'd2
    } pxs_state_e;

    localparam logic [1:0] WinNone = 2'b00;
    localparam logic [1:0] WinP1   = 2'b01;
    localparam logic [1:0] WinP2   = 2'b10;
    localparam logic [1:0] WinTie  = 2'b11;

    function automatic logic [CoordWidth-1:0] pxs_xc(input logic [StreamWidth-1:0] s);
        return s[XcLsb +: CoordWidth];
    endfunction

    function automatic logic [CoordWidth-1:0] pxs_yc(input logic [StreamWidth-1:0] s);
        return s[YcLsb +: CoordWidth];
    endfunction

endpackage

// File: rtl/pxs_frame_tick.sv
// Derives a registered one-cycle end-of-frame pulse from the pixel stream coordinates.
module pxs_frame_tick
    import pxs_score_keeper_pkg::*;
#(
    parameter int unsigned VISIBLECOLS = 640,
    parameter int unsigned VISIBLEROWS = 480
) (
    input  logic                   px_clk,
    input  logic                   reset,
    input  logic [StreamWidth-1:0] RGBStr_i,
    output logic                   tick
);

    localparam logic [CoordWidth-1:0] LastCol = CoordWidth'(VISIBLECOLS - 1);
    localparam logic [CoordWidth-1:0] LastRow = CoordWidth'(VISIBLEROWS - 1);

    logic endframe;
    logic tick_q;

    // Last visible pixel of the frame is on the stream this cycle.
    always_comb begin
        endframe = (pxs_xc(RGBStr_i) == LastCol) && (pxs_yc(RGBStr_i) == LastRow);
    end

    // Register the compare so the pulse is glitch-free and exactly one cycle wide.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= endframe;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pxs_score_keeper.sv
// Two-player goal counter and idle/play/over game FSM; score bus only moves on frame ticks.
module pxs_score_keeper
    import pxs_score_keeper_pkg::*;
#(
    parameter int unsigned MAX_SCORE      = 9,
    parameter int unsigned HOLDOFF_FRAMES = 30,
    parameter int unsigned WIN_FRAMES     = 180,
    parameter int unsigned VISIBLECOLS    = 640,
    parameter int unsigned VISIBLEROWS    = 480
) (
    input  logic                   px_clk,
    input  logic                   reset,
    input  logic [StreamWidth-1:0] RGBStr_i,
    input  logic                   goal_p1,
    input  logic                   goal_p2,
    input  logic                   start,
    output logic [7:0]             score,
    output logic                   playing,
    output logic                   game_over,
    output logic [1:0]             winner
);

    localparam logic [3:0] MaxDigit   = 4'(MAX_SCORE);
    localparam logic [5:0] HoldReload = 6'(HOLDOFF_FRAMES);
    localparam logic [7:0] WinReload  = 8'(WIN_FRAMES - 1);

    logic       tick;
    logic       goal_p1_q, goal_p2_q, start_q;
    logic       goal1_edge, goal2_edge, start_edge;

    pxs_state_e state_q, state_d;
    logic [3:0] p1_q, p1_d, p2_q, p2_d;
    logic       pend1_q, pend1_d, pend2_q, pend2_d;
    logic [5:0] hold1_q, hold1_d, hold2_q, hold2_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] winner_q, winner_d;

    logic [3:0] p1_inc, p2_inc;
    logic       p1_hit, p2_hit, win;

    pxs_frame_tick #(
        .VISIBLECOLS(VISIBLECOLS),
        .VISIBLEROWS(VISIBLEROWS)
    ) u_frame_tick (
        .px_clk  (px_clk),
        .reset   (reset),
        .RGBStr_i(RGBStr_i),
        .tick    (tick)
    );

    // Previous-value registers for rising-edge detection; a held level is one event.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            goal_p1_q <= 1'b0;
            goal_p2_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            goal_p1_q <= goal_p1;
            goal_p2_q <= goal_p2;
            start_q   <= start;
        end
    end

    assign goal1_edge = goal_p1 & ~goal_p1_q;
    assign goal2_edge = goal_p2 & ~goal_p2_q;
    assign start_edge = start & ~start_q;

    // Candidate digits for this tick's commit and whether they land on the winning score.
    always_comb begin
        p1_inc = (pend1_q && (p1_q != MaxDigit)) ? p1_q + 4'd1 : p1_q;
        p2_inc = (pend2_q && (p2_q != MaxDigit)) ? p2_q + 4'd1 : p2_q;
        p1_hit = pend1_q && (p1_inc == MaxDigit);
        p2_hit = pend2_q && (p2_inc == MaxDigit);
        win    = (state_q == StPlay) && tick && (p1_hit || p2_hit);
    end

    // Game state register.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start edges only matter in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start_edge) state_d = StPlay;
            StPlay: if (win) state_d = StOver;
            StOver: if (tick && (timer_q == 8'd0)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Score, pending, hold-off, win-timer and winner next-state.
    always_comb begin
        p1_d     = p1_q;
        p2_d     = p2_q;
        pend1_d  = pend1_q;
        pend2_d  = pend2_q;
        hold1_d  = hold1_q;
        hold2_d  = hold2_q;
        timer_d  = timer_q;
        winner_d = winner_q;
        case (state_q)
            StIdle: begin
                // Fresh game: nothing carries over from the previous one.
                if (start_edge) begin
                    p1_d    = 4'd0;
                    p2_d    = 4'd0;
                    pend1_d = 1'b0;
                    pend2_d = 1'b0;
                    hold1_d = 6'd0;
                    hold2_d = 6'd0;
                end
            end
            StPlay: begin
                if (tick) begin
                    p1_d    = p1_inc;
                    p2_d    = p2_inc;
                    pend1_d = 1'b0;
                    pend2_d = 1'b0;
                    if (pend1_q) begin
                        hold1_d = HoldReload;
                    end else if (hold1_q != 6'd0) begin
                        hold1_d = hold1_q - 6'd1;
                    end
                    if (pend2_q) begin
                        hold2_d = HoldReload;
                    end else if (hold2_q != 6'd0) begin
                        hold2_d = hold2_q - 6'd1;
                    end
                    if (win) begin
                        timer_d = WinReload;
                        if (p1_hit && p2_hit) begin
                            winner_d = WinTie;
                        end else if (p1_hit) begin
                            winner_d = WinP1;
                        end else begin
                            winner_d = WinP2;
                        end
                    end
                end
                // Edges are checked against the post-tick hold-off so a coincident edge
                // is carried to the next frame rather than lost or double counted.
                if (!win) begin
                    if (goal1_edge && (hold1_d == 6'd0)) pend1_d = 1'b1;
                    if (goal2_edge && (hold2_d == 6'd0)) pend2_d = 1'b1;
                end
            end
            StOver: begin
                pend1_d = 1'b0;
                pend2_d = 1'b0;
                if (tick) begin
                    if (timer_q == 8'd0) begin
                        p1_d     = 4'd0;
                        p2_d     = 4'd0;
                        winner_d = WinNone;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            p1_q     <= 4'd0;
            p2_q     <= 4'd0;
            pend1_q  <= 1'b0;
            pend2_q  <= 1'b0;
            hold1_q  <= 6'd0;
            hold2_q  <= 6'd0;
            timer_q  <= 8'd0;
            winner_q <= WinNone;
        end else begin
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            pend1_q  <= pend1_d;
            pend2_q  <= pend2_d;
            hold1_q  <= hold1_d;
            hold2_q  <= hold2_d;
            timer_q  <= timer_d;
            winner_q <= winner_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        playing   = (state_q == StPlay);
        game_over = (state_q == StOver);
        score     = {p2_q, p1_q};
        winner    = winner_q;
    end

endmodule

// File: tb/tb_pxs_score_keeper.sv
// Bench for pxs_score_keeper: directed frame-level table, corner sequences, random vs model.
module tb_pxs_score_keeper;
    import pxs_score_keeper_pkg::*;

    localparam int MaxScore  = 3;
    localparam int Holdoff   = 2;
    localparam int WinFrames = 3;
    localparam int Cols      = 8;
    localparam int Rows      = 4;
    localparam int TotCols   = 10;
    localparam int TotRows   = 6;

    logic        px_clk = 1'b0;
    logic        reset = 1'b1;
    logic        goal_p1 = 1'b0;
    logic        goal_p2 = 1'b0;
    logic        start = 1'b0;
    logic [25:0] RGBStr_i;
    logic [7:0]  score;
    logic        playing;
    logic        game_over;
    logic [1:0]  winner;

    pxs_score_keeper #(
        .MAX_SCORE     (MaxScore),
        .HOLDOFF_FRAMES(Holdoff),
        .WIN_FRAMES    (WinFrames),
        .VISIBLECOLS   (Cols),
        .VISIBLEROWS   (Rows)
    ) dut (
        .px_clk   (px_clk),
        .reset    (reset),
        .RGBStr_i (RGBStr_i),
        .goal_p1  (goal_p1),
        .goal_p2  (goal_p2),
        .start    (start),
        .score    (score),
        .playing  (playing),
        .game_over(game_over),
        .winner   (winner)
    );

    always #5 px_clk = ~px_clk;

    int x = 0;
    int y = 0;
    int n_vec = 0;
    int n_bad = 0;

    // Reference model: game state as plain integers (0 idle, 1 play, 2 over).
    int m_state = 0;
    int m_sc[2];
    int m_hold[2];
    bit m_pend[2];
    int m_timer = 0;
    int m_win = 0;
    bit m_tick = 0;
    bit m_pg[2];
    bit m_ps = 0;

    typedef struct {
        bit         rst;
        bit         st;
        bit         g1;
        bit         g2;
        logic [7:0] sc;
        bit         pl;
        bit         ov;
        logic [1:0] w;
    } row_t;

    row_t rows[28];

    function automatic logic [11:0] dut_out();
        return {score, playing, game_over, winner};
    endfunction

    function automatic logic [11:0] model_out();
        logic [7:0] s;
        s = 8'(m_sc[1] * 16 + m_sc[0]);
        return {s, m_state == 1, m_state == 2, 2'(m_win)};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t: got score=%h play=%b over=%b win=%b, want score=%h play=%b over=%b win=%b",
                     name, $time, got[11:4], got[3], got[2], got[1:0],
                     want[11:4], want[3], want[2], want[1:0]);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired, got no event, want one", name);
    endtask

    task automatic set_stream();
        logic [25:0] s;
        s = 26'($urandom);
        s[XcLsb +: CoordWidth] = CoordWidth'(x);
        s[YcLsb +: CoordWidth] = CoordWidth'(y);
        RGBStr_i = s;
    endtask

    // Applies the game rules to the inputs sampled at this clock edge.
    task automatic model_update();
        bit t;
        bit e[2];
        bit g[2];
        bit se;
        bit won;
        bit reached[2];
        g[0] = goal_p1;
        g[1] = goal_p2;
        t = m_tick;
        if (reset) begin
            m_state = 0; m_timer = 0; m_win = 0; m_tick = 0; m_ps = 0;
            for (int p = 0; p < 2; p++) begin
                m_sc[p] = 0; m_hold[p] = 0; m_pend[p] = 0; m_pg[p] = 0;
            end
            return;
        end
        m_tick = (x == Cols - 1) && (y == Rows - 1);
        for (int p = 0; p < 2; p++) begin
            e[p] = g[p] && !m_pg[p];
            m_pg[p] = g[p];
        end
        se = start && !m_ps;
        m_ps = start;
        case (m_state)
            0: if (se) begin
                m_state = 1;
                for (int p = 0; p < 2; p++) begin
                    m_sc[p] = 0; m_pend[p] = 0; m_hold[p] = 0;
                end
            end
            1: begin
                won = 0;
                reached[0] = 0;
                reached[1] = 0;
                if (t) begin
                    for (int p = 0; p < 2; p++) begin
                        if (m_pend[p]) begin
                            if (m_sc[p] < MaxScore) m_sc[p]++;
                            m_hold[p] = Holdoff;
                            m_pend[p] = 0;
                            reached[p] = (m_sc[p] == MaxScore);
                        end else if (m_hold[p] > 0) begin
                            m_hold[p]--;
                        end
                    end
                    if (reached[0] || reached[1]) begin
                        won = 1;
                        m_state = 2;
                        m_win = int'(reached[0]) + 2 * int'(reached[1]);
                        m_timer = WinFrames - 1;
                    end
                end
                if (!won) begin
                    for (int p = 0; p < 2; p++) begin
                        if (e[p] && m_hold[p] == 0) m_pend[p] = 1;
                    end
                end
            end
            default: begin
                m_pend[0] = 0;
                m_pend[1] = 0;
                if (t) begin
                    if (m_timer == 0) begin
                        m_state = 0; m_sc[0] = 0; m_sc[1] = 0; m_win = 0;
                    end else begin
                        m_timer--;
                    end
                end
            end
        endcase
    endtask

    // One clock: DUT and model take the same inputs, then the raster advances.
    task automatic step();
        @(posedge px_clk);
        model_update();
        #1;
        check("model", dut_out(), model_out());
        x++;
        if (x == TotCols) begin
            x = 0;
            y = (y == TotRows - 1) ? 0 : y + 1;
        end
        set_stream();
    endtask

    task automatic wait_mid();
        int n;
        n = 0;
        while (!(y == 2 && x == 0)) begin
            step();
            n++;
            if (n > 200) begin
                timeout("wait_mid");
                break;
            end
        end
    endtask

    // Runs until the cycle after the next frame tick, when a commit becomes visible.
    task automatic run_past_tick();
        int n;
        n = 0;
        while (!m_tick) begin
            step();
            n++;
            if (n > 200) begin
                timeout("run_past_tick");
                break;
            end
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0]  = '{1, 0, 0, 0, 8'h00, 0, 0, 2'b00};
        rows[1]  = '{0, 1, 0, 0, 8'h00, 1, 0, 2'b00};
        rows[2]  = '{0, 0, 1, 0, 8'h01, 1, 0, 2'b00};
        rows[3]  = '{0, 0, 1, 0, 8'h01, 1, 0, 2'b00};
        rows[4]  = '{0, 0, 0, 0, 8'h01, 1, 0, 2'b00};
        rows[5]  = '{0, 0, 1, 0, 8'h02, 1, 0, 2'b00};
        rows[6]  = '{0, 0, 0, 1, 8'h12, 1, 0, 2'b00};
        rows[7]  = '{1, 0, 0, 0, 8'h00, 0, 0, 2'b00};
        rows[8]  = '{0, 1, 0, 0, 8'h00, 1, 0, 2'b00};
        rows[9]  = '{0, 0, 0, 1, 8'h10, 1, 0, 2'b00};
        rows[10] = '{0, 0, 0, 0, 8'h10, 1, 0, 2'b00};
        rows[11] = '{0, 0, 0, 0, 8'h10, 1, 0, 2'b00};
        rows[12] = '{0, 0, 0, 1, 8'h20, 1, 0, 2'b00};
        rows[13] = '{0, 0, 0, 0, 8'h20, 1, 0, 2'b00};
        rows[14] = '{0, 0, 0, 0, 8'h20, 1, 0, 2'b00};
        rows[15] = '{0, 0, 0, 1, 8'h30, 0, 1, 2'b10};
        rows[16] = '{0, 1, 1, 1, 8'h30, 0, 1, 2'b10};
        rows[17] = '{0, 0, 0, 0, 8'h30, 0, 1, 2'b10};
        rows[18] = '{0, 0, 0, 0, 8'h00, 0, 0, 2'b00};
        rows[19] = '{0, 1, 0, 0, 8'h00, 1, 0, 2'b00};
        rows[20] = '{0, 1, 1, 1, 8'h11, 1, 0, 2'b00};
        rows[21] = '{0, 0, 0, 0, 8'h11, 1, 0, 2'b00};
        rows[22] = '{0, 0, 0, 0, 8'h11, 1, 0, 2'b00};
        rows[23] = '{0, 0, 1, 1, 8'h22, 1, 0, 2'b00};
        rows[24] = '{0, 0, 0, 0, 8'h22, 1, 0, 2'b00};
        rows[25] = '{0, 0, 0, 0, 8'h22, 1, 0, 2'b00};
        rows[26] = '{0, 0, 1, 1, 8'h33, 0, 1, 2'b11};
        rows[27] = '{1, 0, 0, 0, 8'h00, 0, 0, 2'b00};

        m_sc[0] = 0; m_sc[1] = 0; m_hold[0] = 0; m_hold[1] = 0;
        m_pend[0] = 0; m_pend[1] = 0; m_pg[0] = 0; m_pg[1] = 0;
        set_stream();

        // Power-on reset.
        reset = 1'b1;
        step();
        check("reset_state", dut_out(), 12'h000);
        step();
        reset = 1'b0;

        // Frame-level directed table: one row per frame.
        for (int i = 0; i < 28; i++) begin
            if (rows[i].rst) begin
                reset = 1'b1;
                step();
                step();
                reset = 1'b0;
            end
            wait_mid();
            start   = rows[i].st;
            goal_p1 = rows[i].g1;
            goal_p2 = rows[i].g2;
            repeat (5) step();
            start   = 1'b0;
            goal_p1 = 1'b0;
            goal_p2 = 1'b0;
            run_past_tick();
            check($sformatf("row%0d", i), dut_out(),
                  {rows[i].sc, rows[i].pl, rows[i].ov, rows[i].w});
        end

        // Goal edge in the same cycle as the tick is counted on the following tick.
        start = 1'b1;
        step();
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!m_tick) begin
                step();
                n++;
                if (n > 200) begin
                    timeout("coinc_wait");
                    break;
                end
            end
        end
        goal_p2 = 1'b1;
        step();
        goal_p2 = 1'b0;
        check("coinc_same_tick", dut_out(), {8'h00, 1'b1, 1'b0, 2'b00});
        run_past_tick();
        check("coinc_next_tick", dut_out(), {8'h10, 1'b1, 1'b0, 2'b00});

        // Reset with a point pending discards it.
        wait_mid();
        goal_p1 = 1'b1;
        step();
        goal_p1 = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_mid_game", dut_out(), 12'h000);
        run_past_tick();
        check("no_pend_survives", dut_out(), 12'h000);

        // Random traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            reset   = ($urandom_range(0, 999) == 0);
            start   = ($urandom_range(0, 99) == 0);
            goal_p1 = ($urandom_range(0, 19) == 0);
            goal_p2 = ($urandom_range(0, 19) == 0);
            step();
        end
        reset   = 1'b0;
        start   = 1'b0;
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
